disp_syncgen: RTL and testbench

Raster timing generator for the display output path. It sits directly upstream of the display output stage. It produces the free-running HCNT/VCNT counters that stage consumes, plus the VGA_HS/VGA_VS sync outputs aligned to VGA_DE. It also provides a frame-synchronised display enable (DISPON_F), a frame counter and a vertical-blank interrupt pulse. Timing constants come from the shared XGA timing parameter header.

---
 rtl/disp_syncgen_pkg.sv | 27 ++
 rtl/disp_sync2.sv | 25 ++
 rtl/disp_syncgen.sv | 119 +++++++++++
 tb/tb_disp_syncgen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/disp_syncgen_pkg.sv
// Shared XGA raster timing constants, counter widths and sync helpers
// used by the display timing path.
package disp_syncgen_pkg;

  // Counter widths shared with the display output stage
  localparam int H_W = 11;
  localparam int V_W = 10;

  // XGA 1024x768 @ 60 Hz timing; HCNT/VCNT 0 is the start of the front porch
  localparam int XGA_HPERIOD = 1344;
  localparam int XGA_HFRONT  = 24;
  localparam int XGA_HWIDTH  = 136;
  localparam int XGA_HBACK   = 160;
  localparam int XGA_VPERIOD = 806;
  localparam int XGA_VFRONT  = 3;
  localparam int XGA_VWIDTH  = 6;
  localparam int XGA_VBACK   = 29;

  // XGA syncs are active-low
  localparam bit XGA_SYNC_POL = 1'b0;

  // Map an "inside sync window" flag onto the physical pin level
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/disp_sync2.sv
// Two-flop level synchroniser into the pixel clock domain.
module disp_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives a clean level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/disp_syncgen.sv
// Raster timing generator: free-running HCNT/VCNT, HS/VS decoded from the
// next counter state (zero skew to HCNT), frame-synchronised display enable,
// frame counter and vertical-blank interrupt.
module disp_syncgen
  import disp_syncgen_pkg::*;
#(
  parameter int HPERIOD  = XGA_HPERIOD,
  parameter int HFRONT   = XGA_HFRONT,
  parameter int HWIDTH   = XGA_HWIDTH,
  parameter int HBACK    = XGA_HBACK,
  parameter int VPERIOD  = XGA_VPERIOD,
  parameter int VFRONT   = XGA_VFRONT,
  parameter int VWIDTH   = XGA_VWIDTH,
  parameter int VBACK    = XGA_VBACK,
  parameter bit SYNC_POL = XGA_SYNC_POL
) (
  input  logic           PCK,
  input  logic           PRST,
  input  logic           DISPON,
  output logic [H_W-1:0] HCNT,
  output logic [V_W-1:0] VCNT,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           DISPON_F,
  output logic [7:0]     FRAMECNT,
  output logic           VBLANK_IRQ
);

  // Counters must fit their widths; HFRONT>=1 keeps HCNT=0 outside the
  // sync window so the reset level of VGA_HS matches the decode.
  if (HPERIOD > 2048 || VPERIOD > 1024 || HFRONT < 1 ||
      HFRONT + HWIDTH + HBACK >= HPERIOD ||
      VFRONT + VWIDTH + VBACK >= VPERIOD) begin : g_bad_timing
    $error("disp_syncgen: timing parameters out of range");
  end

  localparam logic [H_W-1:0] H_LAST    = H_W'(HPERIOD - 1);
  localparam logic [H_W-1:0] H_SYNC_LO = H_W'(HFRONT);
  localparam logic [H_W-1:0] H_SYNC_HI = H_W'(HFRONT + HWIDTH - 1);
  localparam logic [V_W-1:0] V_LAST    = V_W'(VPERIOD - 1);
  localparam logic [V_W-1:0] V_SYNC_LO = V_W'(VFRONT);
  localparam logic [V_W-1:0] V_SYNC_HI = V_W'(VFRONT + VWIDTH - 1);

  logic [H_W-1:0] r_hcnt;
  logic [V_W-1:0] r_vcnt;
  logic           r_hs;
  logic           r_vs;
  logic           r_dispon_f;
  logic [7:0]     r_framecnt;
  logic           r_irq;

  logic [H_W-1:0] w_hcnt_nxt;
  logic [V_W-1:0] w_vcnt_nxt;
  logic           w_hwrap;
  logic           w_fw;
  logic           w_hs_act;
  logic           w_vs_act;
  logic           w_dsync;

  // Request level crosses into PCK before it is frame-gated
  disp_sync2 u_dispon_sync (
    .i_clk   (PCK),
    .i_rst_n (PRST),
    .i_d     (DISPON),
    .o_q     (w_dsync)
  );

  // Next-state counters; syncs are decoded from these so they line up with HCNT/VCNT
  always_comb begin
    w_hwrap    = (r_hcnt == H_LAST);
    w_fw       = w_hwrap && (r_vcnt == V_LAST);
    w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + H_W'(1);
    w_vcnt_nxt = r_vcnt;
    if (w_hwrap) begin
      w_vcnt_nxt = w_fw ? '0 : r_vcnt + V_W'(1);
    end
    w_hs_act = (w_hcnt_nxt >= H_SYNC_LO) && (w_hcnt_nxt <= H_SYNC_HI);
    w_vs_act = (w_vcnt_nxt >= V_SYNC_LO) && (w_vcnt_nxt <= V_SYNC_HI);
  end

  // Raster counters and sync outputs
  always_ff @(posedge PCK or negedge PRST) begin
    if (!PRST) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      r_hs   <= sync_level(w_hs_act, SYNC_POL);
      r_vs   <= sync_level(w_vs_act, SYNC_POL);
    end
  end

  // Frame-boundary state: enable only changes on whole frames, IRQ marks frame start
  always_ff @(posedge PCK or negedge PRST) begin
    if (!PRST) begin
      r_dispon_f <= 1'b0;
      r_framecnt <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= w_fw;
      if (w_fw) begin
        r_dispon_f <= w_dsync;
        r_framecnt <= r_framecnt + 8'd1;
      end
    end
  end

  assign HCNT       = r_hcnt;
  assign VCNT       = r_vcnt;
  assign VGA_HS     = r_hs;
  assign VGA_VS     = r_vs;
  assign DISPON_F   = r_dispon_f;
  assign FRAMECNT   = r_framecnt;
  assign VBLANK_IRQ = r_irq;

endmodule

// File: tb/tb_disp_syncgen.sv
// Bench for disp_syncgen: a shortened-timing instance checked every cycle via
// an expectation queue, plus a default XGA instance checked at hand-picked points.
`timescale 1ns/1ps
module tb_disp_syncgen;
  import disp_syncgen_pkg::*;

  localparam int HP = 16, HF = 2, HW = 3, HB = 3;
  localparam int VP = 8,  VF = 1, VW = 2, VB = 1;
  localparam int FP = HP * VP;

  logic PCK  = 1'b0;
  logic PRST = 1'b1;
  logic DISPON = 1'b0;

  logic [10:0] HCNT;   logic [9:0] VCNT;
  logic VGA_HS, VGA_VS, DISPON_F, VBLANK_IRQ;
  logic [7:0] FRAMECNT;

  logic [10:0] x_hcnt; logic [9:0] x_vcnt;
  logic x_hs, x_vs, x_dispon_f, x_irq;
  logic [7:0] x_framecnt;

  always #5 PCK = ~PCK;

  disp_syncgen #(
    .HPERIOD(HP), .HFRONT(HF), .HWIDTH(HW), .HBACK(HB),
    .VPERIOD(VP), .VFRONT(VF), .VWIDTH(VW), .VBACK(VB), .SYNC_POL(1'b0)
  ) dut (
    .PCK(PCK), .PRST(PRST), .DISPON(DISPON),
    .HCNT(HCNT), .VCNT(VCNT), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .DISPON_F(DISPON_F), .FRAMECNT(FRAMECNT), .VBLANK_IRQ(VBLANK_IRQ)
  );

  disp_syncgen dut_xga (
    .PCK(PCK), .PRST(PRST), .DISPON(DISPON),
    .HCNT(x_hcnt), .VCNT(x_vcnt), .VGA_HS(x_hs), .VGA_VS(x_vs),
    .DISPON_F(x_dispon_f), .FRAMECNT(x_framecnt), .VBLANK_IRQ(x_irq)
  );

  typedef struct packed {
    int          t;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        f;
    logic [7:0]  fc;
    logic        irq;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int t = 0;            // PCK edges since the last reset release
  logic exp_f = 1'b0;   // expected DISPON_F for the current frame
  int x_hs_low = 0;

  task automatic chk(input string name, input int tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, tag, act, req);
    end
  endtask

  // Expected outputs after t edges of free-running at the short timing
  task automatic push_exp();
    exp_t e;
    int hh, vv;
    hh    = t % HP;
    vv    = (t / HP) % VP;
    e.t   = t;
    e.h   = 11'(hh);
    e.v   = 10'(vv);
    e.hs  = (hh >= HF && hh <= HF + HW - 1) ? 1'b0 : 1'b1;
    e.vs  = (vv >= VF && vv <= VF + VW - 1) ? 1'b0 : 1'b1;
    e.f   = exp_f;
    e.fc  = 8'((t / FP) % 256);
    e.irq = (t > 0 && t % FP == 0) ? 1'b1 : 1'b0;
    q.push_back(e);
  endtask

  task automatic step();
    logic was_run;
    was_run = PRST;
    @(posedge PCK);
    if (was_run) begin
      t++;
      if (t % FP == 0) exp_f = DISPON;
    end
    push_exp();
  endtask

  // DISPON stimulus keyed on raster position in the first frames
  task automatic apply();
    case (t)
      64:      DISPON = 1'b1;   // mid frame 0: must wait for FW at t=128
      168:     DISPON = 1'b0;   // mid frame 1: DISPON_F holds 1 until t=256
      381:     DISPON = 1'b1;   // 3 edges before FW: still caught at t=384
      default: ;
    endcase
  endtask

  // Scoreboard monitor: compare the oldest expectation each cycle
  always @(negedge PCK) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("HCNT",       e_mon.t, int'(HCNT),       int'(e_mon.h));
      chk("VCNT",       e_mon.t, int'(VCNT),       int'(e_mon.v));
      chk("VGA_HS",     e_mon.t, int'(VGA_HS),     int'(e_mon.hs));
      chk("VGA_VS",     e_mon.t, int'(VGA_VS),     int'(e_mon.vs));
      chk("DISPON_F",   e_mon.t, int'(DISPON_F),   int'(e_mon.f));
      chk("FRAMECNT",   e_mon.t, int'(FRAMECNT),   int'(e_mon.fc));
      chk("VBLANK_IRQ", e_mon.t, int'(VBLANK_IRQ), int'(e_mon.irq));
    end
  end

  // Default XGA instance: hand-picked points of the first line
  always @(negedge PCK) begin
    if (PRST) begin
      if (t >= 1 && t <= 1344 && x_hs == 1'b0) x_hs_low++;
      case (t)
        23:   chk("XGA_HS before window", t, int'(x_hs), 1);
        24:   chk("XGA_HS window start",  t, int'(x_hs), 0);
        159:  chk("XGA_HS window end",    t, int'(x_hs), 0);
        160:  chk("XGA_HS after window",  t, int'(x_hs), 1);
        1343: begin
          chk("XGA_HCNT last", t, int'(x_hcnt), 1343);
          chk("XGA_VCNT line0", t, int'(x_vcnt), 0);
          chk("XGA_VS line0", t, int'(x_vs), 1);
        end
        1344: begin
          chk("XGA_HCNT wrap", t, int'(x_hcnt), 0);
          chk("XGA_VCNT inc", t, int'(x_vcnt), 1);
        end
        1345: chk("XGA_HS width", t, x_hs_low, 136);
        default: ;
      endcase
    end
  end

  task automatic chk_reset_now(input string tag);
    chk({tag, " HCNT"},       t, int'(HCNT), 0);
    chk({tag, " VCNT"},       t, int'(VCNT), 0);
    chk({tag, " VGA_HS"},     t, int'(VGA_HS), 1);
    chk({tag, " VGA_VS"},     t, int'(VGA_VS), 1);
    chk({tag, " DISPON_F"},   t, int'(DISPON_F), 0);
    chk({tag, " FRAMECNT"},   t, int'(FRAMECNT), 0);
    chk({tag, " VBLANK_IRQ"}, t, int'(VBLANK_IRQ), 0);
    chk({tag, " XGA_HS"},     t, int'(x_hs), 1);
    chk({tag, " XGA_VS"},     t, int'(x_vs), 1);
    chk({tag, " XGA_FRAMECNT"}, t, int'(x_framecnt), 0);
    chk({tag, " XGA_IRQ"},    t, int'(x_irq), 0);
    chk({tag, " XGA_DISPON_F"}, t, int'(x_dispon_f), 0);
  endtask

  initial begin
    int guard;
    // Power-up reset: values appear without any PCK edge
    #1 PRST = 1'b0;
    #1 chk_reset_now("por");
    repeat (10) step();
    #1 PRST = 1'b1;

    // Frames 0..2 with DISPON toggles, then run through the FRAMECNT wrap
    while (t < 256 * FP + 100) begin
      step();
      #1 apply();
    end

    // Park at HCNT=7/VCNT=5, then reset asynchronously mid-frame
    guard = 0;
    while (t % FP != 5 * HP + 7 && guard < 2 * FP) begin
      step();
      guard++;
    end
    chk("seek mid-frame", t, t % FP, 5 * HP + 7);
    @(negedge PCK);
    #1 PRST = 1'b0;
    #1 chk_reset_now("async");
    t = 0;
    exp_f = 1'b0;
    repeat (3) step();
    #1 PRST = 1'b1;

    // DISPON is still 1: DISPON_F must stay 0 until the first FW after release
    while (t < FP + 40) step();

    @(negedge PCK);
    @(negedge PCK);
    chk("queue drained", t, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
